// File: rtl/draw_line.sv
// Bresenham line rasteriser: one draw-point update per clock from (X0,Y0) to (X1,Y1).
// Latency: first update visible 2 cycles after the start edge; done pulses 1 cycle after the last point.
// Backpressure: ul1Hold freezes stepping; optional DRAW_LINE_CLIP_EN suppresses updates outside P_X_MAX/P_Y_MAX.
module draw_line #(
    parameter int P_X_MAX = 319,
    parameter int P_Y_MAX = 239
) (
    input  logic        ul1Clock,
    input  logic        ul1Reset_n,
    input  logic        ul1Start,
    input  logic [8:0]  ul9X0,
    input  logic [8:0]  ul9Y0,
    input  logic [8:0]  ul9X1,
    input  logic [8:0]  ul9Y1,
    input  logic [11:0] ul12Color,
    input  logic        ul1Hold,
    output logic        ul1Busy,
    output logic        ul1Done,
    output logic        ul1Update,
    output logic [8:0]  ul9PosX,
    output logic [8:0]  ul9PosY,
    output logic [11:0] ul12Rgb12Data
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STEP, S_DONE} state_t;

`ifdef DRAW_LINE_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [8:0]         x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [8:0]         x_q, x_d, y_q, y_d;
    logic [11:0]        col_q, col_d;
    logic signed [11:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic               sxn_q, sxn_d, syn_q, syn_d;
    logic               busy_q, busy_d, done_q, done_d, upd_q, upd_d;
    logic [8:0]         posx_q, posx_d, posy_q, posy_d;
    logic [11:0]        rgb_q, rgb_d;

    logic [8:0]         adx, ady;
    logic signed [12:0] e2, dx_w, dy_w;
    logic               in_range, vis;

    assign adx  = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    assign ady  = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    // e2 is one bit wider than err so doubling can never overflow.
    assign e2   = {err_q, 1'b0};
    assign dx_w = {dx_q[11], dx_q};
    assign dy_w = {dy_q[11], dy_q};

    assign in_range = (x_q <= P_X_MAX[8:0]) && (y_q <= P_Y_MAX[8:0]);
    assign vis      = !CLIP_EN || in_range;

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        sxn_d   = sxn_q;
        syn_d   = syn_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        upd_d   = 1'b0;
        posx_d  = posx_q;
        posy_d  = posy_q;
        rgb_d   = rgb_q;
        case (state_q)
            S_IDLE: begin
                if (ul1Start) begin
                    x0_d    = ul9X0;
                    y0_d    = ul9Y0;
                    x1_d    = ul9X1;
                    y1_d    = ul9Y1;
                    col_d   = ul12Color;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                dx_d    = $signed({3'b000, adx});
                dy_d    = 12'sd0 - $signed({3'b000, ady});
                err_d   = $signed({3'b000, adx}) - $signed({3'b000, ady});
                sxn_d   = !(x0_q < x1_q);
                syn_d   = !(y0_q < y1_q);
                x_d     = x0_q;
                y_d     = y0_q;
                state_d = S_STEP;
            end
            S_STEP: begin
                if (!ul1Hold) begin
                    upd_d  = vis;
                    posx_d = x_q;
                    posy_d = y_q;
                    rgb_d  = col_q;
                    if (x_q == x1_q && y_q == y1_q) begin
                        state_d = S_DONE;
                    end else begin
                        if (e2 >= dy_w) begin
                            err_d = err_d + dy_q;
                            x_d   = sxn_q ? (x_q - 9'd1) : (x_q + 9'd1);
                        end
                        if (e2 <= dx_w) begin
                            err_d = err_d + dx_q;
                            y_d   = syn_q ? (y_q - 9'd1) : (y_q + 9'd1);
                        end
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
        if (!ul1Reset_n) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sxn_q   <= 1'b0;
            syn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            upd_q   <= 1'b0;
            posx_q  <= '0;
            posy_q  <= '0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sxn_q   <= sxn_d;
            syn_q   <= syn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            upd_q   <= upd_d;
            posx_q  <= posx_d;
            posy_q  <= posy_d;
            rgb_q   <= rgb_d;
        end
    end

    assign ul1Busy       = busy_q;
    assign ul1Done       = done_q;
    assign ul1Update     = upd_q;
    assign ul9PosX       = posx_q;
    assign ul9PosY       = posy_q;
    assign ul12Rgb12Data = rgb_q;

endmodule
